score_display_ctrl: RTL and testbench

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_display_ctrl.sv | 158 +++++++++++++++
 tb/tb_score_display_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// Two-player score display: captures both scores, converts them to BCD by
// sequential double-dabble, and multiplexes four seven-segment digits.
module score_display_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [6:0] score_a,
  input  logic [6:0] score_b,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned SR_W    = 15;
  localparam int unsigned DISP_W  = 16;
  localparam int unsigned REF_W   = 16;
  localparam int unsigned STEP_W  = 3;
  localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(6);
  localparam logic [REF_W-1:0]   REF_MAX   = REF_W'(REFRESH_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(99);
  localparam logic [6:0]         SEG_OFF   = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [SR_W-1:0]     sr_a_q, sr_a_d, sr_b_q, sr_b_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                busy_q, busy_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic [1:0]          idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          an_q, an_d;
  logic                dp_q, dp_d;
  logic [3:0]          digit;
  logic                is_tens;

  function automatic logic [SCORE_W-1:0] sat99(input logic [SCORE_W-1:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

  // One double-dabble iteration: sr = {tens, units, remaining binary}.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7] + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[SR_W-2:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_OFF;
    endcase
  endfunction

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      sr_a_q  <= '0;
      sr_b_q  <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sr_a_q  <= sr_a_d;
      sr_b_q  <= sr_b_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  // Capture / convert / commit sequencing; the display only changes in COMMIT.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    sr_a_d  = sr_a_q;
    sr_b_d  = sr_b_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = CONVERT;
          step_d  = '0;
          sr_a_d  = SR_W'(sat99(score_a));
          sr_b_d  = SR_W'(sat99(score_b));
        end
      end
      CONVERT: begin
        sr_a_d = dd_step(sr_a_q);
        sr_b_d = dd_step(sr_b_q);
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = {sr_a_q[14:7], sr_b_q[14:7]};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Free-running digit scan, decoupled from the conversion FSM.
  always_comb begin
    ref_d   = ref_q + REF_W'(1);
    idx_d   = idx_q;
    digit   = 4'd0;
    is_tens = 1'b0;
    an_d    = 4'b1111;
    if (ref_q == REF_MAX) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end
    case (idx_q)
      2'd0: begin an_d = 4'b1110; digit = disp_q[11:8];  end
      2'd1: begin an_d = 4'b1101; digit = disp_q[15:12]; is_tens = 1'b1; end
      2'd2: begin an_d = 4'b1011; digit = disp_q[3:0];   end
      default: begin an_d = 4'b0111; digit = disp_q[7:4]; is_tens = 1'b1; end
    endcase
    if (is_tens && (BLANK_LZ != 0) && (digit == 4'd0)) seg_d = SEG_OFF;
    else                                               seg_d = seg_enc(digit);
    dp_d = (idx_q != 2'd2);
  end

  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: busy timing checked inline,
// scanned digits checked by a scoreboard monitor against a decimal model.
module tb_score_display_ctrl;

  localparam int unsigned DIV = 4;

  typedef struct {
    int         sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [6:0] score_a = '0;
  logic [6:0] score_b = '0;
  logic       busy, dp, busy2, dp2;
  logic [6:0] seg, seg2;
  logic [3:0] an, an2;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [6:0] obs_seg;
  logic [3:0] obs_an;
  logic       obs_dp;

  always #5 pclk = ~pclk;

  score_display_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (
    .pclk(pclk), .rst(rst), .score_a(score_a), .score_b(score_b), .load(load),
    .busy(busy), .seg(seg), .an(an), .dp(dp)
  );

  score_display_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(0)) dut_nb (
    .pclk(pclk), .rst(rst), .score_a(score_a), .score_b(score_b), .load(load),
    .busy(busy2), .seg(seg2), .an(an2), .dp(dp2)
  );

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected scan for one display: {A units, A tens, B units, B tens}.
  task automatic expect_display(input int sel, input int a, input int b, input bit blank);
    exp_t e;
    int sa, sb;
    sa = (a > 99) ? 99 : a;
    sb = (b > 99) ? 99 : b;
    e.sel = sel;
    e.an = 4'b1110; e.seg = ref_seg(sa % 10); e.dp = 1'b1; sb_q.push_back(e);
    e.an = 4'b1101; e.seg = (blank && (sa / 10 == 0)) ? 7'b1111111 : ref_seg(sa / 10);
    sb_q.push_back(e);
    e.an = 4'b1011; e.seg = ref_seg(sb % 10); e.dp = 1'b0; sb_q.push_back(e);
    e.an = 4'b0111; e.seg = (blank && (sb / 10 == 0)) ? 7'b1111111 : ref_seg(sb / 10);
    e.dp = 1'b1; sb_q.push_back(e);
  endtask

  always @(negedge pclk) begin
    if (!rst && sb_q.size() != 0) begin
      mon_e   = sb_q[0];
      obs_an  = (mon_e.sel != 0) ? an2  : an;
      obs_seg = (mon_e.sel != 0) ? seg2 : seg;
      obs_dp  = (mon_e.sel != 0) ? dp2  : dp;
      if (obs_an === mon_e.an) begin
        tests_run++;
        if (obs_seg !== mon_e.seg || obs_dp !== mon_e.dp) begin
          tests_failed++;
          $display("FAIL scan dut%0d an=%b: seg=%b dp=%b, required seg=%b dp=%b",
                   mon_e.sel, obs_an, obs_seg, obs_dp, mon_e.seg, mon_e.dp);
        end
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_load(input int a, input int b);
    score_a = 7'(a);
    score_b = 7'(b);
    load    = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 128 && sb_q.size() != 0; n++) step();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s scan timeout: %0d entries pending, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_load(input int a, input int b, output bit ok);
    step();
    do_load(a, b);
    step();
    load = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      step();
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    tests_run++;
    if (seg !== 7'b1111111 || an !== 4'b1111 || dp !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: seg=%b an=%b dp=%b busy=%b, required 1111111 1111 1 0",
               seg, an, dp, busy);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: an=%b seg=%b dp=%b, required 1110 1000000 1", an, seg, dp);
    end
    repeat (3) step();
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (seg !== 7'b1111111 || an !== 4'b1111 || dp !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: seg=%b an=%b dp=%b busy=%b, required 1111111 1111 1 0",
               seg, an, dp, busy);
    end
    #1 rst = 1'b0;
    step();
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_async_release: an=%b seg=%b dp=%b, required 1110 1000000 1",
               an, seg, dp);
    end
  endtask

  task automatic test_normal();
    step();
    do_load(42, 7);
    for (int i = 0; i <= 8; i++) begin
      step();
      if (i == 0) load = 1'b0;
      tests_run++;
      if (busy !== (i < 8)) begin
        tests_failed++;
        $display("FAIL normal_busy edge k+%0d: busy=%b, required %b", i, busy, (i < 8));
      end
    end
    repeat (2) step();
    expect_display(0, 42, 7, 1'b1);
    wait_drain("normal");
  endtask

  task automatic test_saturation();
    bit ok;
    run_load(120, 0, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL saturation_busy: busy=%b, required 0 within 20 cycles", busy);
    end
    expect_display(0, 120, 0, 1'b1);
    wait_drain("saturation");
  endtask

  task automatic test_load_while_busy();
    step();
    do_load(5, 0);
    for (int i = 0; i <= 9; i++) begin
      step();
      tests_run++;
      if (busy !== (i < 8)) begin
        tests_failed++;
        $display("FAIL busy_ignore edge k+%0d: busy=%b, required %b", i, busy, (i < 8));
      end
      if (i == 2 || i == 7) do_load(9, 0);
      else load = 1'b0;
    end
    load = 1'b0;
    step();
    expect_display(0, 5, 0, 1'b1);
    wait_drain("load_while_busy");
  endtask

  task automatic test_reset_mid_convert();
    int hits;
    step();
    do_load(0, 10);
    for (int i = 0; i <= 2; i++) begin
      step();
      load = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || an !== 4'b1111) begin
      tests_failed++;
      $display("FAIL abort_reset: busy=%b an=%b, required 0 1111", busy, an);
    end
    #1 rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (seg === 7'b1111001) hits++;
    end
    tests_run++;
    if (busy !== 1'b0 || hits != 0) begin
      tests_failed++;
      $display("FAIL abort_no_commit: busy=%b ones_seen=%0d, required 0 0", busy, hits);
    end
    expect_display(0, 0, 0, 1'b1);
    wait_drain("reset_mid_convert");
  endtask

  task automatic test_blank();
    bit ok;
    run_load(3, 10, ok);
    tests_run++;
    if (!ok || busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL blank_busy: busy=%b busy2=%b, required 0 0", busy, busy2);
    end
    expect_display(0, 3, 10, 1'b1);
    expect_display(1, 3, 10, 1'b0);
    wait_drain("blank");
  endtask

  task automatic test_back_to_back();
    bit ok;
    step();
    do_load(11, 22);
    for (int i = 0; i <= 9; i++) begin
      step();
      tests_run++;
      if (busy !== ((i < 8) || (i == 9))) begin
        tests_failed++;
        $display("FAIL back_to_back edge k+%0d: busy=%b, required %b",
                 i, busy, ((i < 8) || (i == 9)));
      end
      if (i == 8) do_load(33, 44);
      else load = 1'b0;
    end
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      step();
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL back_to_back_done: busy=%b, required 0 within 20 cycles", busy);
    end
    repeat (2) step();
    expect_display(0, 33, 44, 1'b1);
    wait_drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_saturation();
    test_load_while_busy();
    test_reset_mid_convert();
    test_blank();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
